// File: rtl/rr_merge_ctrl_pkg.sv
// Shared definitions for the round-robin merge controller
// and any future arbiters built on rr_pick.
package rr_merge_ctrl_pkg;

    // Width of an index into n channels, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_merge_ctrl_pick.sv
// Combinational round-robin picker: first request after `last`,
// found by rotating a doubled request vector and priority-encoding.
module rr_pick
    import rr_merge_ctrl_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] idx,
    output logic            any
);

    int         start;
    logic [N-1:0] rot;

    // Rotate so the slot after `last` sits at bit 0, then take the lowest set bit.
    always_comb begin
        start = (int'(last) + 1) % N;
        rot   = N'({req, req} >> start);
        idx   = '0;
        any   = 1'b0;
        for (int p = N - 1; p >= 0; p--) begin
            if (rot[p]) begin
                idx = SELW'((start + p) % N);
                any = 1'b1;
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_merge_ctrl.sv
// N-to-1 round-robin merge for the rdy/ack fabric: one registered
// output slot, one-hot load strobe and registered source index.
module rr_merge_ctrl
    import rr_merge_ctrl_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = sel_width(N)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    src_rdys,
    output logic [N-1:0]    src_acks,
    output logic            dst_rdy,
    input  logic            dst_ack,
    output logic [SELW-1:0] o_sel,
    output logic [N-1:0]    o_load
);

    logic            can_load;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] last;
    logic [SELW-1:0] gidx;
    logic            any;

    // The slot can take a new item when empty or being drained this cycle.
    assign can_load = !dst_rdy || dst_ack;
    assign req      = can_load ? src_rdys : '0;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req  (req),
        .last (last),
        .gnt  (gnt),
        .idx  (gidx),
        .any  (any)
    );

    assign src_acks = gnt;
    assign o_load   = gnt;

    // Slot occupancy, owner index and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            dst_rdy <= 1'b0;
            o_sel   <= '0;
            last    <= SELW'(N - 1);
        end else if (any) begin
            dst_rdy <= 1'b1;
            o_sel   <= gidx;
            last    <= gidx;
        end else if (dst_ack) begin
            dst_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_merge_ctrl.sv
// Scoreboard bench: directed N=4 sequences and a randomised N=1
// Forward-style run with an item-level scoreboard.
module tb_rr_merge_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] rdys;
    logic [3:0] acks;
    logic [3:0] load;
    logic       drdy;
    logic       dack;
    logic [1:0] sel;

    logic [0:0] rdy1;
    logic [0:0] ack1;
    logic [0:0] load1;
    logic       drdy1;
    logic       dack1;
    logic [0:0] sel1;

    rr_merge_ctrl #(.N(4)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .src_rdys (rdys),
        .src_acks (acks),
        .dst_rdy  (drdy),
        .dst_ack  (dack),
        .o_sel    (sel),
        .o_load   (load)
    );

    rr_merge_ctrl #(.N(1)) dut1 (
        .i_clk    (clk),
        .i_rst    (rst),
        .src_rdys (rdy1),
        .src_acks (ack1),
        .dst_rdy  (drdy1),
        .dst_ack  (dack1),
        .o_sel    (sel1),
        .o_load   (load1)
    );

    typedef struct {
        logic [3:0] acks;
        logic       rdy;
        logic [1:0] sel;
        string      tag;
    } exp_t;

    exp_t expq[$];
    int   itemq[$];
    int   checks = 0;
    int   errors = 0;

    int   cur = 0;
    int   next_id = 1;
    int   dreg = 0;
    int   n_in = 0;
    int   n_out = 0;
    logic acked = 1'b0;
    logic n1_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic r,
                        input logic [3:0] rv, input logic da,
                        input logic [3:0] ea, input logic er,
                        input logic [1:0] es);
        @(posedge clk);
        #1;
        rst  = r;
        rdys = rv;
        dack = da;
        expq.push_back('{ea, er, es, tag});
    endtask

    // N=4 monitor: one expected tuple per stimulus cycle.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk({e.tag, " acks"}, 32'(acks), 32'(e.acks));
            chk({e.tag, " load"}, 32'(load), 32'(e.acks));
            chk({e.tag, " rdy"}, 32'(drdy), 32'(e.rdy));
            chk({e.tag, " sel"}, 32'(sel), 32'(e.sel));
        end
    end

    // Owner data register for the N=1 channel.
    always @(posedge clk) begin
        if (load1[0]) dreg <= cur;
    end

    // N=1 monitor: slot occupancy, transfers in order, acks recorded.
    always @(negedge clk) begin
        if (n1_on) begin
            chk("n1 rdy", 32'(drdy1), 32'(itemq.size() > 0));
            if (drdy1 && dack1) begin
                n_out++;
                chk("n1 sel", 32'(sel1), 32'd0);
                if (itemq.size() == 0) begin
                    chk("n1 extra item", 32'(dreg), 32'hffffffff);
                end else begin
                    chk("n1 item", 32'(dreg), 32'(itemq.pop_front()));
                end
            end
            if (ack1[0]) begin
                chk("n1 ack needs rdy", 32'(rdy1), 32'd1);
                itemq.push_back(cur);
                acked = 1'b1;
                n_in++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst   = 1'b0;
        rdys  = '0;
        dack  = 1'b0;
        rdy1  = '0;
        dack1 = 1'b0;
        repeat (2) @(posedge clk);
        step("rst", 0, 4'b0000, 0, 4'b0000, 0, 2'd0);

        step("t1c0", 1, 4'b1111, 1, 4'b0001, 0, 2'd0);
        step("t1c1", 1, 4'b1111, 1, 4'b0010, 1, 2'd0);
        step("t1c2", 1, 4'b1111, 1, 4'b0100, 1, 2'd1);
        step("t1c3", 1, 4'b1111, 1, 4'b1000, 1, 2'd2);
        step("t1c4", 1, 4'b1111, 1, 4'b0001, 1, 2'd3);
        step("t1c5", 1, 4'b1111, 1, 4'b0010, 1, 2'd0);

        step("t2grant", 1, 4'b0100, 1, 4'b0100, 1, 2'd1);
        for (int i = 0; i < 5; i++)
            step("t2hold", 1, 4'b1011, 0, 4'b0000, 1, 2'd2);
        step("t2rel", 1, 4'b1011, 1, 4'b1000, 1, 2'd2);

        step("t3a", 1, 4'b0100, 1, 4'b0100, 1, 2'd3);
        for (int i = 0; i < 3; i++)
            step("t3b", 1, 4'b0100, 1, 4'b0100, 1, 2'd2);

        step("t4grant", 1, 4'b0010, 1, 4'b0010, 1, 2'd2);
        step("t4drain", 1, 4'b0000, 1, 4'b0000, 1, 2'd1);
        step("t4empty", 1, 4'b0000, 0, 4'b0000, 0, 2'd1);
        step("t4wrap", 1, 4'b0011, 0, 4'b0001, 0, 2'd1);
        step("t4next", 1, 4'b0010, 1, 4'b0010, 1, 2'd0);

        step("t5grant", 1, 4'b1000, 1, 4'b1000, 1, 2'd1);
        step("t5rst", 0, 4'b0000, 0, 4'b0000, 1, 2'd3);
        step("t5post", 1, 4'b0000, 0, 4'b0000, 0, 2'd0);
        step("t5pri", 1, 4'b1001, 0, 4'b0001, 0, 2'd0);
        step("t5next", 1, 4'b1001, 1, 4'b1000, 1, 2'd0);
        step("t5idle", 1, 4'b0000, 1, 4'b0000, 1, 2'd3);
        step("t5idle2", 1, 4'b0000, 0, 4'b0000, 0, 2'd3);

        repeat (2) @(posedge clk);
        chk("n4 queue drained", 32'(expq.size()), 32'd0);

        @(posedge clk);
        #1;
        n1_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (acked) begin
                rdy1  = '0;
                acked = 1'b0;
            end
            if (!rdy1[0] && ($urandom_range(1, 0) == 1)) begin
                rdy1 = 1'b1;
                cur  = next_id;
                next_id++;
            end
            dack1 = 1'($urandom_range(1, 0));
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (acked) begin
                rdy1  = '0;
                acked = 1'b0;
            end
            dack1 = 1'b1;
        end
        @(posedge clk);
        #1;
        n1_on = 1'b0;
        chk("n1 drained", 32'(itemq.size()), 32'd0);
        chk("n1 in/out", 32'(n_out), 32'(n_in));
        chk("n1 all sent", 32'(n_in), 32'(next_id - 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
